fetch_decode: RTL and testbench

- Upstream neighbour of the execute stage.
- Fetches one 16-bit CHIP-8 opcode from program memory at the current PC and advances the PC by one word.
- Reads Vx and Vy from the register file, decodes the opcode into the 6-bit operation code, and presents one operation to execute as a single-cycle issue.
- Sequences instructions so that execute's registered PC, SP and I writes land before the next fetch.

---
 rtl/fetch_decode.sv | 229 ++++++++++++++++++++++
 tb/tb_fetch_decode.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// fetch_decode: CHIP-8 fetch / register-read / decode stage feeding the execute stage.
// Optional: define ILLEGAL_TRAP_EN to halt in a terminal TRAP state on an undecodable opcode.
module fetch_decode #(
    parameter int ADDR_W        = 12,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [15:0]       mem_r_data,
    input  logic [15:0]       pc_rd,
    output logic [15:0]       pc_wr,
    output logic              pc_en,
    output logic [3:0]        rx_addr,
    output logic [3:0]        ry_addr,
    input  logic [7:0]        rx_data,
    input  logic [7:0]        ry_data,
    output logic [5:0]        decode,
    output logic [7:0]        val,
    output logic [3:0]        x,
    output logic [11:0]       addr,
    output logic [7:0]        vx,
    output logic [7:0]        vy,
    input  logic              exec_busy,
    output logic              illegal,
    output logic              trap
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_REGRD  = 3'd3,
        S_ISSUE  = 3'd4,
        S_SETTLE = 3'd5
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP   = 3'd6
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        decode_q, decode_d;
    logic [7:0]        val_q, val_d;
    logic [3:0]        x_q, x_d;
    logic [11:0]       addr_q, addr_d;
    logic [7:0]        vx_q, vx_d;
    logic [7:0]        vy_q, vy_d;
    logic              illegal_q, illegal_d;
    logic [5:0]        op_code;
`ifdef ILLEGAL_TRAP_EN
    logic              trap_q, trap_d;
`endif

    // Opcode to operation code; 0 marks an undecodable opcode.
    function automatic logic [5:0] decode_op(input logic [15:0] op);
        logic [5:0] d;
        d = 6'd0;
        case (op[15:12])
            4'h0: begin
                if (op == 16'h00E0)      d = 6'd1;
                else if (op == 16'h00EE) d = 6'd2;
            end
            4'h1: d = 6'd3;
            4'h2: d = 6'd4;
            4'h3: d = 6'd5;
            4'h4: d = 6'd6;
            4'h5: if (op[3:0] == 4'h0) d = 6'd7;
            4'h6: d = 6'd8;
            4'h7: d = 6'd9;
            4'h8: begin
                if (op[3] == 1'b0)         d = 6'd10 + {3'b000, op[2:0]};
                else if (op[3:0] == 4'hE)  d = 6'd18;
            end
            4'h9: if (op[3:0] == 4'h0) d = 6'd19;
            4'hA: d = 6'd20;
            4'hB: d = 6'd21;
            4'hC: d = 6'd22;
            4'hD: d = 6'd23;
            4'hE: begin
                if (op[7:0] == 8'h9E)      d = 6'd24;
                else if (op[7:0] == 8'hA1) d = 6'd25;
            end
            4'hF: begin
                case (op[7:0])
                    8'h07:   d = 6'd26;
                    8'h0A:   d = 6'd27;
                    8'h15:   d = 6'd28;
                    8'h18:   d = 6'd29;
                    8'h1E:   d = 6'd30;
                    8'h29:   d = 6'd32;
                    8'h33:   d = 6'd33;
                    8'h55:   d = 6'd34;
                    8'h65:   d = 6'd35;
                    default: d = 6'd0;
                endcase
            end
            default: d = 6'd0;
        endcase
        return d;
    endfunction

    assign op_code = decode_op(ir_q);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        decode_d  = 6'd0;
        illegal_d = 1'b0;
        val_d     = val_q;
        x_d       = x_q;
        addr_d    = addr_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
`ifdef ILLEGAL_TRAP_EN
        trap_d    = trap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                ir_d    = mem_r_data;
                state_d = S_REGRD;
            end
            S_REGRD: begin
                // Register data is sampled at the end of REGRD so vx/vy are valid with decode.
                decode_d  = op_code;
                illegal_d = (op_code == 6'd0);
                val_d     = ir_q[7:0];
                x_d       = ir_q[11:8];
                addr_d    = ir_q[11:0];
                vx_d      = rx_data;
                vy_d      = ry_data;
`ifdef ILLEGAL_TRAP_EN
                if (op_code == 6'd0) trap_d = 1'b1;
`endif
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                // The ISSUE cycle itself counts as the first settle cycle.
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                state_d = S_SETTLE;
`ifdef ILLEGAL_TRAP_EN
                if (trap_q) state_d = S_TRAP;
`endif
            end
            S_SETTLE: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!exec_busy) begin
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ir_q      <= 16'h0000;
            cnt_q     <= '0;
            decode_q  <= 6'd0;
            illegal_q <= 1'b0;
            val_q     <= 8'h00;
            x_q       <= 4'h0;
            addr_q    <= 12'h000;
            vx_q      <= 8'h00;
            vy_q      <= 8'h00;
`ifdef ILLEGAL_TRAP_EN
            trap_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            decode_q  <= decode_d;
            illegal_q <= illegal_d;
            val_q     <= val_d;
            x_q       <= x_d;
            addr_q    <= addr_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
`ifdef ILLEGAL_TRAP_EN
            trap_q    <= trap_d;
`endif
        end
    end

    // Strobes and addresses are pure functions of the registered state and ir.
    assign mem_r_en   = (state_q == S_FETCH);
    assign mem_r_addr = mem_r_en ? pc_rd[ADDR_W-1:0] : '0;
    assign pc_en      = (state_q == S_LATCH);
    assign pc_wr      = pc_en ? (pc_rd + 16'd1) : 16'h0000;
    assign rx_addr    = (ir_q[15:12] == 4'hB) ? 4'h0 : ir_q[11:8];
    assign ry_addr    = ir_q[7:4];

    assign decode  = decode_q;
    assign illegal = illegal_q;
    assign val     = val_q;
    assign x       = x_q;
    assign addr    = addr_q;
    assign vx      = vx_q;
    assign vy      = vy_q;
`ifdef ILLEGAL_TRAP_EN
    assign trap    = trap_q;
`else
    assign trap    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed vectors for fetch_decode against a program memory,
// PC register and register file modelled in the bench.
`timescale 1ns/1ps
module tb_fetch_decode;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              exec_busy;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [15:0]       mem_r_data;
    logic [15:0]       pc_rd;
    logic [15:0]       pc_wr;
    logic              pc_en;
    logic [3:0]        rx_addr;
    logic [3:0]        ry_addr;
    logic [7:0]        rx_data;
    logic [7:0]        ry_data;
    logic [5:0]        decode;
    logic [7:0]        val;
    logic [3:0]        x;
    logic [11:0]       addr;
    logic [7:0]        vx;
    logic [7:0]        vy;
    logic              illegal;
    logic              trap;

    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0]  rf  [0:15];
    logic        pc_set;
    logic [15:0] pc_set_val;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_decode #(.ADDR_W(ADDR_W), .SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data),
        .pc_rd      (pc_rd),
        .pc_wr      (pc_wr),
        .pc_en      (pc_en),
        .rx_addr    (rx_addr),
        .ry_addr    (ry_addr),
        .rx_data    (rx_data),
        .ry_data    (ry_data),
        .decode     (decode),
        .val        (val),
        .x          (x),
        .addr       (addr),
        .vx         (vx),
        .vy         (vy),
        .exec_busy  (exec_busy),
        .illegal    (illegal),
        .trap       (trap)
    );

    // Program memory with registered read, and the PC register owned by execute.
    always @(posedge clk) begin
        if (mem_r_en) mem_r_data <= mem[mem_r_addr];
        if (pc_set)     pc_rd <= pc_set_val;
        else if (pc_en) pc_rd <= pc_wr;
    end

    assign rx_data = rf[rx_addr];
    assign ry_data = rf[ry_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] pc);
        rst        = 1'b0;
        run        = 1'b0;
        exec_busy  = 1'b0;
        pc_set     = 1'b1;
        pc_set_val = pc;
        step();
        step();
        rst    = 1'b1;
        pc_set = 1'b0;
        run    = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b0; exec_busy = 1'b0; pc_set = 1'b1; pc_set_val = 16'h0123;
        step();
        vectors++;
        if ({mem_r_en, mem_r_addr, pc_wr, pc_en, rx_addr, ry_addr, decode, val, x, addr,
             vx, vy, illegal, trap} !== '0) begin
            miscompares++;
            $display("FAIL reset_zero: got en=%b addr=%h pc_en=%b dec=%0d vx=%h vy=%h trap=%b, want all 0",
                     mem_r_en, mem_r_addr, pc_en, decode, vx, vy, trap);
        end
        run = 1'b1;
        step();
        vectors++;
        if (mem_r_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_holds: got mem_r_en=%b with rst low, want 0", mem_r_en);
        end
        $display("reset: outputs cleared");
    endtask

    task automatic test_ldi();
        mem[12'h200] = 16'h6A3C;
        start(16'h0200);
        step();
        vectors++;
        if ({mem_r_en, mem_r_addr} !== {1'b1, 12'h200}) begin
            miscompares++;
            $display("FAIL ldi_fetch: got en=%b addr=%h, want en=1 addr=200", mem_r_en, mem_r_addr);
        end
        step();
        vectors++;
        if ({pc_en, pc_wr} !== {1'b1, 16'h0201}) begin
            miscompares++;
            $display("FAIL ldi_pc: got pc_en=%b pc_wr=%h, want pc_en=1 pc_wr=0201", pc_en, pc_wr);
        end
        step();
        vectors++;
        if (decode !== 6'd0) begin
            miscompares++;
            $display("FAIL ldi_early: got decode=%0d in REGRD, want 0", decode);
        end
        step();
        vectors++;
        if ({decode, x, val, illegal} !== {6'd8, 4'hA, 8'h3C, 1'b0}) begin
            miscompares++;
            $display("FAIL ldi_issue: got dec=%0d x=%h val=%h ill=%b, want dec=8 x=a val=3c ill=0",
                     decode, x, val, illegal);
        end
        $display("issue pc=0200 op=6A3C decode=%0d x=%h val=%h", decode, x, val);
        run = 1'b0;
        step();
        step();
        step();
        vectors++;
        if ({mem_r_en, decode, pc_rd} !== {1'b0, 6'd0, 16'h0201}) begin
            miscompares++;
            $display("FAIL ldi_idle: got en=%b dec=%0d pc=%h, want en=0 dec=0 pc=0201",
                     mem_r_en, decode, pc_rd);
        end
    endtask

    task automatic test_alu();
        logic quiet;
        rf[1] = 8'h10;
        rf[2] = 8'h20;
        mem[12'h210] = 16'h8125;
        start(16'h0210);
        quiet = 1'b1;
        step(); quiet &= (decode == 6'd0);
        step(); quiet &= (decode == 6'd0);
        step(); quiet &= (decode == 6'd0);
        vectors++;
        if ({rx_addr, ry_addr} !== {4'h1, 4'h2}) begin
            miscompares++;
            $display("FAIL alu_regrd: got rx=%h ry=%h, want rx=1 ry=2", rx_addr, ry_addr);
        end
        step();
        vectors++;
        if ({decode, vx, vy} !== {6'd15, 8'h10, 8'h20}) begin
            miscompares++;
            $display("FAIL alu_issue: got dec=%0d vx=%h vy=%h, want dec=15 vx=10 vy=20", decode, vx, vy);
        end
        $display("issue pc=0210 op=8125 decode=%0d vx=%h vy=%h", decode, vx, vy);
        run = 1'b0;
        step(); quiet &= (decode == 6'd0);
        step(); quiet &= (decode == 6'd0);
        vectors++;
        if (quiet !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_quiet: got decode nonzero outside ISSUE, want 0");
        end
    endtask

    task automatic test_jump_v0();
        rf[0] = 8'h05;
        rf[3] = 8'h99;
        mem[12'h220] = 16'hB300;
        start(16'h0220);
        step(); step(); step();
        vectors++;
        if (rx_addr !== 4'h0) begin
            miscompares++;
            $display("FAIL bnnn_rx: got rx_addr=%h, want 0", rx_addr);
        end
        step();
        vectors++;
        if ({decode, vx, addr} !== {6'd21, 8'h05, 12'h300}) begin
            miscompares++;
            $display("FAIL bnnn_issue: got dec=%0d vx=%h addr=%h, want dec=21 vx=05 addr=300",
                     decode, vx, addr);
        end
        $display("issue pc=0220 op=B300 decode=%0d vx=%h addr=%h", decode, vx, addr);
        run = 1'b0;
        step(); step();
    endtask

    task automatic test_back_to_back_illegal();
        mem[12'h300] = 16'h00EE;
        mem[12'h301] = 16'hFFFF;
        mem[12'h302] = 16'h6000;
        start(16'h0300);
        step(); step(); step(); step();
        vectors++;
        if ({decode, illegal} !== {6'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL ret_issue: got dec=%0d ill=%b, want dec=2 ill=0", decode, illegal);
        end
        $display("issue pc=0300 op=00EE decode=%0d", decode);
        step();
        step();
        vectors++;
        if ({mem_r_en, mem_r_addr} !== {1'b1, 12'h301}) begin
            miscompares++;
            $display("FAIL b2b_fetch: got en=%b addr=%h, want en=1 addr=301", mem_r_en, mem_r_addr);
        end
        step(); step(); step();
        vectors++;
        if ({decode, illegal} !== {6'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL ill_issue: got dec=%0d ill=%b, want dec=0 ill=1", decode, illegal);
        end
        $display("issue pc=0301 op=FFFF decode=%0d illegal=%b trap=%b", decode, illegal, trap);
`ifdef ILLEGAL_TRAP_EN
        vectors++;
        if (trap !== 1'b1) begin
            miscompares++;
            $display("FAIL trap_set: got trap=%b, want 1", trap);
        end
`else
        vectors++;
        if (trap !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_tied: got trap=%b, want 0", trap);
        end
`endif
        step();
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_pulse: got illegal=%b after ISSUE, want 0", illegal);
        end
`ifdef ILLEGAL_TRAP_EN
        begin
            logic halted;
            halted = 1'b1;
            for (int i = 0; i < 8; i++) begin
                step();
                halted &= !mem_r_en && !pc_en && trap;
            end
            vectors++;
            if (halted !== 1'b1) begin
                miscompares++;
                $display("FAIL trap_halt: got fetch or pc_en or trap drop in TRAP, want none");
            end
        end
`else
        step();
        vectors++;
        if ({mem_r_en, mem_r_addr} !== {1'b1, 12'h302}) begin
            miscompares++;
            $display("FAIL ill_continue: got en=%b addr=%h, want en=1 addr=302", mem_r_en, mem_r_addr);
        end
        run = 1'b0;
        step(); step(); step(); step(); step();
`endif
    endtask

    task automatic test_exec_busy();
        logic quiet;
        mem[12'h400] = 16'h6000;
        mem[12'h401] = 16'h6000;
        start(16'h0400);
        step(); step(); step(); step();
        $display("issue pc=0400 op=6000 decode=%0d", decode);
        exec_busy = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            quiet &= !mem_r_en;
        end
        step();
        quiet &= !mem_r_en;
        exec_busy = 1'b0;
        vectors++;
        if (quiet !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_hold: got mem_r_en while exec_busy high, want none");
        end
        step();
        vectors++;
        if ({mem_r_en, mem_r_addr} !== {1'b1, 12'h401}) begin
            miscompares++;
            $display("FAIL busy_release: got en=%b addr=%h, want en=1 addr=401", mem_r_en, mem_r_addr);
        end
        run = 1'b0;
        step(); step(); step(); step(); step();
    endtask

    task automatic test_run_drop();
        logic quiet;
        mem[12'h500] = 16'h7105;
        start(16'h0500);
        step();
        step();
        run = 1'b0;
        step();
        step();
        vectors++;
        if ({decode, x, val} !== {6'd9, 4'h1, 8'h05}) begin
            miscompares++;
            $display("FAIL drop_issue: got dec=%0d x=%h val=%h, want dec=9 x=1 val=05", decode, x, val);
        end
        $display("issue pc=0500 op=7105 decode=%0d (run dropped in LATCH)", decode);
        step();
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            quiet &= !mem_r_en && (decode == 6'd0);
        end
        vectors++;
        if (quiet !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_idle: got activity after run dropped, want idle");
        end
    endtask

    task automatic test_reset_mid();
        logic quiet;
        mem[12'h600] = 16'hA123;
        start(16'h0600);
        step(); step(); step();
        rst = 1'b0;
        step();
        vectors++;
        if ({mem_r_en, mem_r_addr, pc_wr, pc_en, rx_addr, ry_addr, decode, val, x, addr,
             vx, vy, illegal, trap} !== '0) begin
            miscompares++;
            $display("FAIL midrst_zero: got dec=%0d rx=%h ry=%h val=%h addr=%h vx=%h, want all 0",
                     decode, rx_addr, ry_addr, val, addr, vx);
        end
        rst = 1'b1;
        run = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            quiet &= !mem_r_en && (decode == 6'd0);
        end
        vectors++;
        if (quiet !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_noissue: got issue or fetch after reset, want none");
        end
        $display("reset in REGRD: pending issue dropped");
    endtask

    task automatic test_pc_wrap();
        mem[12'hFFF] = 16'h1234;
        start(16'hFFFF);
        step();
        vectors++;
        if ({mem_r_en, mem_r_addr} !== {1'b1, 12'hFFF}) begin
            miscompares++;
            $display("FAIL wrap_fetch: got en=%b addr=%h, want en=1 addr=fff", mem_r_en, mem_r_addr);
        end
        step();
        vectors++;
        if ({pc_en, pc_wr} !== {1'b1, 16'h0000}) begin
            miscompares++;
            $display("FAIL wrap_pc: got pc_en=%b pc_wr=%h, want pc_en=1 pc_wr=0000", pc_en, pc_wr);
        end
        step();
        step();
        vectors++;
        if ({decode, addr} !== {6'd3, 12'h234}) begin
            miscompares++;
            $display("FAIL wrap_issue: got dec=%0d addr=%h, want dec=3 addr=234", decode, addr);
        end
        $display("issue pc=FFFF op=1234 decode=%0d addr=%h", decode, addr);
        run = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; exec_busy = 1'b0; pc_set = 1'b0; pc_set_val = 16'h0000;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        test_reset();
        test_ldi();
        test_alu();
        test_jump_v0();
        test_back_to_back_illegal();
        test_exec_busy();
        test_run_drop();
        test_reset_mid();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
